muldiv_unit: RTL and testbench

Iterative RV32M multiply/divide execution unit, the multi-cycle companion to the single-cycle ALU control path. It decodes `func3`/`func7` for the M extension (`func7 = 7'b0000001`) and runs one radix-2 shift-add multiply or restoring divide per request. Results are returned with a one-cycle `done` pulse. It sits in the execute stage beside the ALU, and the pipeline stalls on `busy`.

---
 rtl/muldiv_if.sv | 19 +
 rtl/muldiv_unit.sv | 148 ++++++++++++++
 tb/tb_muldiv_unit.sv | 211 +++++++++++++++++++++
 3 files changed

// File: rtl/muldiv_if.sv
// muldiv_if: request/response bundle for the iterative RV32M mul/div unit.
//   start/func3/func7/op_a/op_b/flush : request side, driven by the execute stage
//   busy/done/result                  : status and result, driven by the unit
interface muldiv_if #(parameter int XLEN = 32);
    logic            start;
    logic [2:0]      func3;
    logic [6:0]      func7;
    logic [XLEN-1:0] op_a;
    logic [XLEN-1:0] op_b;
    logic            flush;
    logic            busy;
    logic            done;
    logic [XLEN-1:0] result;

    modport master (output start, func3, func7, op_a, op_b, flush,
                    input  busy, done, result);
    modport slave  (input  start, func3, func7, op_a, op_b, flush,
                    output busy, done, result);
endinterface

// File: rtl/muldiv_unit.sv
// muldiv_unit: iterative RV32M multiply/divide. One radix-2 shift-add multiply
// or restoring divide per request, XLEN iterations, then a sign-fix cycle.
//   clk   : rising-edge clock
//   rst_n : asynchronous active-low reset
//   bus   : muldiv_if.slave (start/func3/func7/op_a/op_b/flush in,
//           busy/done/result out)
module muldiv_unit #(
    parameter int XLEN = 32
) (
    input logic     clk,
    input logic     rst_n,
    muldiv_if.slave bus
);
    localparam int CW = $clog2(XLEN);
    localparam logic [XLEN-1:0] MIN_NEG = {1'b1, {(XLEN-1){1'b0}}};

    typedef enum logic [1:0] {S_IDLE, S_CALC, S_FIX, S_DONE} state_t;

    state_t          state_q, state_d;
    logic [CW-1:0]   cnt_q;
    logic [2:0]      f3_q;
    logic            sa_q, sb_q;
    logic [XLEN-1:0] mag_a_q, mag_b_q;
    // acc: running high product half / partial remainder
    // lo : multiplier being consumed / dividend shifting into quotient
    logic [XLEN-1:0] acc_q, lo_q;
    logic [XLEN-1:0] result_q;

    // ---------------- request decode ----------------
    logic            accept, special;
    logic            sgn_a, sgn_b, neg_a, neg_b, is_div;
    logic [XLEN-1:0] in_mag_a, in_mag_b, spec_res;

    always_comb begin
        sgn_a = 1'b0;
        sgn_b = 1'b0;
        case (bus.func3)
            3'b000, 3'b001, 3'b100, 3'b110: begin sgn_a = 1'b1; sgn_b = 1'b1; end
            3'b010:                         sgn_a = 1'b1;
            default: ;
        endcase
    end

    assign accept   = bus.start && (bus.func7 == 7'b0000001) && !bus.flush &&
                      (state_q == S_IDLE || state_q == S_DONE);
    assign is_div   = bus.func3[2];
    assign neg_a    = sgn_a & bus.op_a[XLEN-1];
    assign neg_b    = sgn_b & bus.op_b[XLEN-1];
    assign in_mag_a = neg_a ? -bus.op_a : bus.op_a;
    assign in_mag_b = neg_b ? -bus.op_b : bus.op_b;

    logic div0, ovf;
    assign div0     = is_div && (bus.op_b == '0);
    // only DIV/REM (func3[0]==0) can overflow
    assign ovf      = is_div && !bus.func3[0] && (bus.op_a == MIN_NEG) && (bus.op_b == '1);
    assign special  = div0 | ovf;
    assign spec_res = div0 ? (bus.func3[1] ? bus.op_a : '1)
                           : (bus.func3[1] ? '0 : bus.op_a);

    // ---------------- iteration datapath ----------------
    logic [XLEN:0]   mul_sum, div_r;
    logic [XLEN-1:0] div_diff;
    logic            div_ge;

    assign mul_sum  = {1'b0, acc_q} + (lo_q[0] ? {1'b0, mag_a_q} : '0);
    assign div_r    = {acc_q, lo_q[XLEN-1]};
    assign div_ge   = div_r >= {1'b0, mag_b_q};
    // difference always fits XLEN bits when div_ge holds
    assign div_diff = div_r[XLEN-1:0] - mag_b_q;

    // ---------------- sign fix / output select ----------------
    logic [2*XLEN-1:0] prod_s;
    logic [XLEN-1:0]   quo_s, rem_s, fix_res;

    assign prod_s = (sa_q ^ sb_q) ? -{acc_q, lo_q} : {acc_q, lo_q};
    assign quo_s  = (sa_q ^ sb_q) ? -lo_q : lo_q;
    assign rem_s  = sa_q ? -acc_q : acc_q;

    always_comb begin
        case (f3_q)
            3'b000:                 fix_res = prod_s[XLEN-1:0];
            3'b001, 3'b010, 3'b011: fix_res = prod_s[2*XLEN-1:XLEN];
            3'b100, 3'b101:         fix_res = quo_s;
            default:                fix_res = rem_s;
        endcase
    end

    // ---------------- FSM ----------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= S_IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE, S_DONE: begin
                state_d = S_IDLE;
                if (accept) state_d = special ? S_DONE : S_CALC;
            end
            S_CALC: begin
                if (bus.flush)                     state_d = S_IDLE;
                else if (cnt_q == CW'(XLEN - 1))   state_d = S_FIX;
            end
            S_FIX:   state_d = bus.flush ? S_IDLE : S_DONE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q    <= '0;
            f3_q     <= '0;
            sa_q     <= 1'b0;
            sb_q     <= 1'b0;
            mag_a_q  <= '0;
            mag_b_q  <= '0;
            acc_q    <= '0;
            lo_q     <= '0;
            result_q <= '0;
        end else if (accept) begin
            cnt_q   <= '0;
            f3_q    <= bus.func3;
            sa_q    <= neg_a;
            sb_q    <= neg_b;
            mag_a_q <= in_mag_a;
            mag_b_q <= in_mag_b;
            acc_q   <= '0;
            lo_q    <= is_div ? in_mag_a : in_mag_b;
            if (special) result_q <= spec_res;
        end else if (state_q == S_CALC) begin
            cnt_q <= cnt_q + 1'b1;
            if (f3_q[2]) begin
                acc_q <= div_ge ? div_diff : div_r[XLEN-1:0];
                lo_q  <= {lo_q[XLEN-2:0], div_ge};
            end else begin
                acc_q <= mul_sum[XLEN:1];
                lo_q  <= {mul_sum[0], lo_q[XLEN-1:1]};
            end
        end else if (state_q == S_FIX && !bus.flush) begin
            result_q <= fix_res;
        end
    end

    assign bus.busy   = (state_q == S_CALC) || (state_q == S_FIX);
    assign bus.done   = (state_q == S_DONE);
    assign bus.result = result_q;
endmodule

// File: tb/tb_muldiv_unit.sv
// tb_muldiv_unit: directed + randomized bench for muldiv_unit (XLEN=32).
// Expected results come from plain 64-bit arithmetic; expected done/busy
// timing comes from the issue cycle of each request.
module tb_muldiv_unit;
    localparam int XLEN = 32;
    localparam int LAT  = XLEN + 2;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    muldiv_if #(.XLEN(XLEN)) bus ();
    muldiv_unit #(.XLEN(XLEN)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

    typedef struct { int cyc; logic [31:0] val; } exp_t;
    exp_t        q[$];
    int          cyc = 0;
    int          busy_from = 1, busy_to = 0;
    logic [31:0] exp_result = '0;
    int          errors = 0, checks = 0;
    logic        mon_ed;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s cycle %0d: got %h expected %h", name, cyc, act, exp);
        end
    endtask

    function automatic logic [31:0] model(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
        longint sa, sb, ua, ub, p;
        logic [63:0] pv;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        ua = longint'({32'b0, a});
        ub = longint'({32'b0, b});
        case (f)
            3'd0: p = sa * sb;
            3'd1: p = (sa * sb) >>> 32;
            3'd2: p = (sa * ub) >>> 32;
            3'd3: p = (ua * ub) >> 32;
            3'd4: p = (b == 0) ? -1 : (a == 32'h80000000 && b == 32'hffffffff) ? sa : sa / sb;
            3'd5: p = (b == 0) ? -1 : ua / ub;
            3'd6: p = (b == 0) ? sa : (a == 32'h80000000 && b == 32'hffffffff) ? 0 : sa % sb;
            default: p = (b == 0) ? ua : ua % ub;
        endcase
        pv = p;
        return pv[31:0];
    endfunction

    // Compare process: done/busy/result every cycle against the expectation queue.
    always @(negedge clk) begin
        if (rst_n) begin
            mon_ed = 1'b0;
            if (q.size() > 0 && q[0].cyc == cyc) begin
                mon_ed     = 1'b1;
                exp_result = q[0].val;
                void'(q.pop_front());
            end
            chk("done", {31'b0, bus.done}, {31'b0, mon_ed});
            chk("busy", {31'b0, bus.busy}, {31'b0, (cyc >= busy_from && cyc <= busy_to)});
            chk("result", bus.result, exp_result);
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_until(input int c);
        while (cyc < c) step();
    endtask

    // Drive one start pulse in the current cycle. When push is set, the
    // expected completion is queued; done_c returns its cycle.
    task automatic issue(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                         input logic [6:0] f7, input bit push, input logic [31:0] val,
                         output int done_c);
        int  c0;
        bit  spec;
        c0 = cyc;
        bus.start = 1'b1; bus.func3 = f3; bus.func7 = f7; bus.op_a = a; bus.op_b = b;
        spec   = f3[2] && (b == 0 || ((f3 == 3'b100 || f3 == 3'b110) && a == 32'h80000000 && b == 32'hffffffff));
        done_c = spec ? c0 + 1 : c0 + LAT;
        if (push) begin
            q.push_back('{done_c, val});
            busy_from = c0 + 1;
            busy_to   = spec ? c0 : c0 + XLEN + 1;
        end
        step();
        bus.start = 1'b0;
        bus.op_a  = $urandom; bus.op_b = $urandom; bus.func3 = 3'($urandom);
    endtask

    task automatic lit(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] val, output int done_c);
        chk("model_pin", model(f3, a, b), val);
        issue(f3, a, b, 7'b0000001, 1'b1, val, done_c);
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (q.size() > 0 && n < 200) begin step(); n++; end
        if (q.size() > 0) begin
            checks++; errors++;
            $display("FAIL drain_timeout cycle %0d: got %0d pending expected 0", cyc, q.size());
            q.delete();
        end
        step();
    endtask

    function automatic logic [31:0] pick();
        case ($urandom_range(0, 6))
            0: return 32'h0;
            1: return 32'h1;
            2: return 32'hffffffff;
            3: return 32'h80000000;
            4: return 32'($urandom_range(0, 20));
            default: return $urandom;
        endcase
    endfunction

    initial begin
        int dc, c0;
        logic [2:0]  f;
        logic [31:0] a, b;
        bus.start = 0; bus.func3 = 0; bus.func7 = 0; bus.op_a = 0; bus.op_b = 0; bus.flush = 0;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        repeat (2) step();

        // back-to-back multiplies
        lit(3'd0, 32'd7, 32'hfffffffd, 32'hffffffeb, dc);
        wait_until(dc);
        lit(3'd3, 32'hffffffff, 32'hffffffff, 32'hfffffffe, dc);
        drain();
        // high halves
        lit(3'd1, 32'h80000000, 32'h80000000, 32'h40000000, dc); drain();
        lit(3'd2, 32'hffffffff, 32'hffffffff, 32'hffffffff, dc); drain();
        lit(3'd1, 32'hffffffff, 32'h00000001, 32'hffffffff, dc); drain();
        // divide signs
        lit(3'd4, 32'hfffffff9, 32'd2, 32'hfffffffd, dc); drain();
        lit(3'd6, 32'hfffffff9, 32'd2, 32'hffffffff, dc); drain();
        lit(3'd5, 32'd100, 32'd7, 32'd14, dc); drain();
        lit(3'd7, 32'd100, 32'd7, 32'd2, dc); drain();
        lit(3'd6, 32'd7, 32'hfffffffe, 32'd1, dc); drain();
        // special divides
        lit(3'd4, 32'd5, 32'd0, 32'hffffffff, dc); drain();
        lit(3'd7, 32'd5, 32'd0, 32'd5, dc); drain();
        lit(3'd4, 32'h80000000, 32'hffffffff, 32'h80000000, dc); drain();
        lit(3'd6, 32'h80000000, 32'hffffffff, 32'd0, dc); drain();
        // ignored requests
        issue(3'd0, 32'd9, 32'd9, 7'b0000000, 1'b0, 32'd0, dc);
        repeat (40) step();
        c0 = cyc;
        lit(3'd0, 32'd1234, 32'd5678, 32'd7006652, dc);
        wait_until(c0 + 5);
        issue(3'd5, 32'd9, 32'd3, 7'b0000001, 1'b0, 32'd0, dc);
        drain();
        // flush mid-divide: no done, result held
        c0 = cyc;
        lit(3'd5, 32'd1000, 32'd7, 32'd142, dc);
        wait_until(c0 + 10);
        bus.flush = 1'b1; q.delete(); busy_to = c0 + 10;
        step();
        bus.flush = 1'b0;
        repeat (40) step();
        // async reset mid-multiply
        c0 = cyc;
        lit(3'd0, 32'd11, 32'd13, 32'd143, dc);
        wait_until(c0 + 20);
        #1 rst_n = 1'b0;
        #1;
        chk("rst_busy", {31'b0, bus.busy}, 32'd0);
        chk("rst_done", {31'b0, bus.done}, 32'd0);
        chk("rst_result", bus.result, 32'd0);
        q.delete(); exp_result = '0; busy_from = 1; busy_to = 0;
        step(); step();
        rst_n = 1'b1;
        step();
        lit(3'd0, 32'd3, 32'd4, 32'd12, dc); drain();

        // randomized, mixed back-to-back and gapped issue
        for (int i = 0; i < 60; i++) begin
            f = 3'($urandom_range(0, 7));
            a = pick();
            b = pick();
            issue(f, a, b, 7'b0000001, 1'b1, model(f, a, b), dc);
            if ($urandom_range(0, 1) == 1 && i != 59) wait_until(dc);
            else begin
                drain();
                repeat ($urandom_range(0, 2)) step();
            end
        end
        drain();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog cycle %0d: got no finish expected finish", cyc);
        $fatal(1, "watchdog");
    end
endmodule
